// File: rtl/eth_pkg.sv
// Shared Ethernet RMII definitions: receive FSM states, dibit codes and the CRC-32 step
// used by both the transmit framer and the receive deframer.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } rx_state_t;

    localparam logic [1:0]  DIBIT_PREAMBLE = 2'b01;
    localparam logic [1:0]  DIBIT_SFD      = 2'b11;

    localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL  = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB_20E3;

    // Advance a reflected CRC-32 by one dibit; dibit[0] is the earlier wire bit.
    function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] dibit);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            if (c[0] ^ dibit[i]) begin
                c = (c >> 1) ^ CRC_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/rmii_dibit_delay.sv
// Purpose: DEPTH-deep 2-bit shift register that holds back the trailing FCS dibits.
// Latency: dout is the dibit shifted in DEPTH shifts earlier; fill saturates at DEPTH.
// Backpressure: none; advances only when shift=1, clr restarts the fill count.
module rmii_dibit_delay #(
    parameter int DEPTH  = 16,
    parameter int FILL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift,
    input  logic [1:0]        din,
    output logic [1:0]        dout,
    output logic [FILL_W-1:0] fill
);

    logic [1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= 2'b00;
            end
            fill <= '0;
        end else begin
            if (shift) begin
                sr[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    sr[i] <= sr[i-1];
                end
            end
            if (clr) begin
                fill <= '0;
            end else if (shift && (fill != FILL_W'(DEPTH))) begin
                fill <= fill + 1'b1;
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/rmii_rx_deframer.sv
// Purpose: strip RMII preamble/SFD and FCS, forward payload dibits, flag CRC/length verdict per frame;
//          RMII_RX_STATS_EN adds good/bad frame counters.
// Latency: 16 cycles sample-to-axiov; frame_done one cycle after crsdv drops. Backpressure: none (line-rate stream).
module rmii_rx_deframer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_MIN = 4,
    parameter int MAX_DIBITS   = 6072,
    parameter int CNT_W        = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        crsdv,
    input  logic [1:0]  rxd,
    output logic        axiov,
    output logic [1:0]  axiod,
    output logic        frame_done,
    output logic        fcs_ok
`ifdef RMII_RX_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`endif
);

    localparam int PRE_W     = $clog2(PREAMBLE_MIN + 1);
    localparam int DLY_DEPTH = 16;
    localparam int FILL_W    = $clog2(DLY_DEPTH + 1);

    rx_state_t          state;
    rx_state_t          state_nxt;
    logic [PRE_W-1:0]   pre_cnt;
    logic [CNT_W-1:0]   dib_cnt;
    logic [31:0]        crc;

    logic               pre_load;
    logic               pre_inc;
    logic               sfd_hit;
    logic               data_shift;
    logic               drop_exit;
    logic               frame_good;

    logic               axiov_nxt;
    logic [1:0]         axiod_nxt;
    logic               frame_done_nxt;
    logic               fcs_ok_nxt;

    logic [1:0]         dly_dout;
    logic [FILL_W-1:0]  dly_fill;

    rmii_dibit_delay #(
        .DEPTH  (DLY_DEPTH),
        .FILL_W (FILL_W)
    ) u_delay (
        .clk   (clk),
        .rst   (rst),
        .clr   (sfd_hit),
        .shift (data_shift),
        .din   (rxd),
        .dout  (dly_dout),
        .fill  (dly_fill)
    );

    // Residue check covers data+FCS; length must be whole bytes and within FCS..max.
    assign frame_good = (crc == CRC_RESIDUE)
                     && (dib_cnt[1:0] == 2'b00)
                     && (dib_cnt >= CNT_W'(DLY_DEPTH))
                     && (dib_cnt <= CNT_W'(MAX_DIBITS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        axiov_nxt      = 1'b0;
        axiod_nxt      = axiod;
        frame_done_nxt = 1'b0;
        fcs_ok_nxt     = 1'b0;
        pre_load       = 1'b0;
        pre_inc        = 1'b0;
        sfd_hit        = 1'b0;
        data_shift     = 1'b0;
        drop_exit      = 1'b0;
        case (state)
            IDLE: begin
                if (crsdv) begin
                    if (rxd == DIBIT_PREAMBLE) begin
                        state_nxt = PREAMBLE;
                        pre_load  = 1'b1;
                    end else begin
                        state_nxt = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!crsdv) begin
                    state_nxt = IDLE;
                end else if (rxd == DIBIT_PREAMBLE) begin
                    pre_inc = 1'b1;
                end else if ((rxd == DIBIT_SFD) && (pre_cnt >= PRE_W'(PREAMBLE_MIN))) begin
                    state_nxt = DATA;
                    sfd_hit   = 1'b1;
                end else begin
                    state_nxt = DROP;
                end
            end
            DATA: begin
                if (crsdv) begin
                    data_shift = 1'b1;
                    if (dly_fill == FILL_W'(DLY_DEPTH)) begin
                        axiov_nxt = 1'b1;
                        axiod_nxt = dly_dout;
                    end
                end else begin
                    frame_done_nxt = 1'b1;
                    fcs_ok_nxt     = frame_good;
                    state_nxt      = IDLE;
                end
            end
            DROP: begin
                if (!crsdv) begin
                    state_nxt = IDLE;
                    drop_exit = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // pre_cnt only needs to reach PREAMBLE_MIN, so it saturates there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
            dib_cnt <= '0;
            crc     <= CRC_INIT;
        end else begin
            if (pre_load) begin
                pre_cnt <= PRE_W'(1);
            end else if (pre_inc && (pre_cnt != PRE_W'(PREAMBLE_MIN))) begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            if (sfd_hit) begin
                dib_cnt <= '0;
                crc     <= CRC_INIT;
            end else if (data_shift) begin
                crc <= crc32_dibit(crc, rxd);
                if (dib_cnt != CNT_W'(MAX_DIBITS + 1)) begin
                    dib_cnt <= dib_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            axiov      <= 1'b0;
            axiod      <= 2'b00;
            frame_done <= 1'b0;
            fcs_ok     <= 1'b0;
        end else begin
            axiov      <= axiov_nxt;
            axiod      <= axiod_nxt;
            frame_done <= frame_done_nxt;
            fcs_ok     <= fcs_ok_nxt;
        end
    end

`ifdef RMII_RX_STATS_EN
    // Counters move on the same edge that raises frame_done, so they are current with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            good_cnt <= 16'h0000;
            bad_cnt  <= 16'h0000;
        end else begin
            if (frame_done_nxt) begin
                if (fcs_ok_nxt) begin
                    good_cnt <= good_cnt + 16'h0001;
                end else begin
                    bad_cnt <= bad_cnt + 16'h0001;
                end
            end else if (drop_exit) begin
                bad_cnt <= bad_cnt + 16'h0001;
            end
        end
    end
`else
    logic stats_unused;
    assign stats_unused = drop_exit;
`endif

endmodule
